// File: rtl/rank_filter_if.sv
// Pixel-window stream and result bus for the rank-order filter.
interface rank_filter_if #(
    parameter int WIDTH = 8,
    parameter int NPIX  = 9
);
    localparam int RW = $clog2(NPIX);

    logic [WIDTH-1:0] DI;
    logic             DSI;
    logic [RW-1:0]    RANK;
    logic [WIDTH-1:0] DO;
    logic             DSO;
    logic             BUSY;
    logic             ERR;

    modport master (output DI, DSI, RANK, input DO, DSO, BUSY, ERR);
    modport slave  (input DI, DSI, RANK, output DO, DSO, BUSY, ERR);
endinterface

// File: rtl/rank_filter.sv
// Rank-order filter: serially loads an NPIX-pixel window into a circular
// chain, then runs repeated max-extraction passes until the requested rank
// has been pulled out. RANK 0 = max, NPIX-1 = min, (NPIX-1)/2 = median.
module rank_filter #(
    parameter int WIDTH = 8,
    parameter int NPIX  = 9
) (
    input logic          CLK,
    input logic          nRST,
    rank_filter_if.slave bus
);
    localparam int RW = $clog2(NPIX);
    localparam int PW = $clog2(NPIX + 1);
    localparam logic [RW-1:0] LAST  = RW'(NPIX - 1);
    localparam logic [PW-1:0] PFULL = PW'(NPIX);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r [NPIX];
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] do_q, do_d;
    logic             dso_q, dso_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [RW-1:0]    cyc_q, cyc_d;
    logic [RW-1:0]    pass_q, pass_d;
    logic [RW-1:0]    rank_q, rank_d;
    logic             ld, run;

    // Compare stage: the chain tail is compared with the running max; the
    // running max restarts from zero on the first cycle of every pass so the
    // previously extracted value stays out of the chain.
    logic [WIDTH-1:0] x, m, mx, mn;
    assign x  = r[NPIX-1];
    assign m  = (cyc_q == '0) ? '0 : m_q;
    assign mx = (x > m) ? x : m;
    assign mn = (x > m) ? m : x;

    // Next-state, counter and output decode
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        do_d    = do_q;
        dso_d   = dso_q;
        err_d   = 1'b0;
        pcnt_d  = pcnt_q;
        cyc_d   = cyc_q;
        pass_d  = pass_q;
        rank_d  = rank_q;
        ld      = 1'b0;
        run     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.DSI) begin
                    state_d = LOAD;
                    ld      = 1'b1;
                    pcnt_d  = PW'(1);
                    dso_d   = 1'b0;
                end
            end
            LOAD: begin
                if (bus.DSI) begin
                    ld     = 1'b1;
                    pcnt_d = (pcnt_q == PFULL) ? pcnt_q : pcnt_q + 1'b1;
                end else if (pcnt_q == PFULL) begin
                    state_d = RUN;
                    cyc_d   = '0;
                    pass_d  = '0;
                    rank_d  = (bus.RANK > LAST) ? LAST : bus.RANK;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    pcnt_d  = '0;
                end
            end
            RUN: begin
                if (bus.DSI) begin
                    state_d = LOAD;
                    ld      = 1'b1;
                    pcnt_d  = PW'(1);
                end else begin
                    run = 1'b1;
                    m_d = mx;
                    if (cyc_q == LAST) begin
                        cyc_d = '0;
                        if (pass_q < rank_q) begin
                            pass_d = pass_q + 1'b1;
                        end else begin
                            state_d = DONE;
                            do_d    = mx;
                            dso_d   = 1'b1;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.DSI) begin
                    state_d = LOAD;
                    ld      = 1'b1;
                    pcnt_d  = PW'(1);
                    dso_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == RUN);
    end

    // Control state and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            m_q     <= '0;
            do_q    <= '0;
            dso_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            pcnt_q  <= '0;
            cyc_q   <= '0;
            pass_q  <= '0;
            rank_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            do_q    <= do_d;
            dso_q   <= dso_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            pcnt_q  <= pcnt_d;
            cyc_q   <= cyc_d;
            pass_q  <= pass_d;
            rank_q  <= rank_d;
        end
    end

    // Circular pixel chain: head takes the new pixel on load, the smaller
    // compare result on run; every other stage shifts by one.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < NPIX; i++) r[i] <= '0;
        end else if (ld || run) begin
            r[0] <= ld ? bus.DI : mn;
            for (int unsigned i = 1; i < NPIX; i++) r[i] <= r[i-1];
        end
    end

    assign bus.DO   = do_q;
    assign bus.DSO  = dso_q;
    assign bus.ERR  = err_q;
    assign bus.BUSY = busy_q;
endmodule

// File: tb/tb_rank_filter.sv
// Scoreboard bench for rank_filter: a 3x3/8-bit instance for directed cases
// and a 5x5/10-bit instance for random windows, both against a sort model.
module tb_rank_filter;
    logic CLK;
    logic nRST;

    rank_filter_if #(.WIDTH(8),  .NPIX(9))  b9();
    rank_filter_if #(.WIDTH(10), .NPIX(25)) b25();

    rank_filter #(.WIDTH(8),  .NPIX(9))  u9  (.CLK(CLK), .nRST(nRST), .bus(b9.slave));
    rank_filter #(.WIDTH(10), .NPIX(25)) u25 (.CLK(CLK), .nRST(nRST), .bus(b25.slave));

    typedef struct {
        int val;
        int lat;
    } exp_t;

    exp_t q9[$];
    exp_t q25[$];
    exp_t e9, e25;
    int   checks = 0;
    int   errors = 0;
    int   cnt9 = 0, cnt25 = 0;
    int   errs9 = 0, errs25 = 0;
    logic dp9 = 1'b0, dp25 = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampr(input int npix, input int rank);
        return (rank > npix - 1) ? npix - 1 : rank;
    endfunction

    // Reference: sort the last npix pixels descending and index by rank
    function automatic int model(input int px[$], input int npix, input int rank);
        int w[$];
        for (int i = px.size() - npix; i < px.size(); i++) w.push_back(px[i]);
        w.rsort();
        return w[clampr(npix, rank)];
    endfunction

    // Edges since DSI was last sampled high
    always @(posedge CLK) begin
        cnt9  <= b9.DSI  ? 0 : cnt9 + 1;
        cnt25 <= b25.DSI ? 0 : cnt25 + 1;
    end

    // Monitor: pop expectation on every DSO rise
    always @(negedge CLK) begin
        if (nRST) begin
            if (b9.ERR)  errs9++;
            if (b25.ERR) errs25++;
            if (b9.DSO && !dp9) begin
                if (q9.size() == 0) chk("dso9_unexpected", 1, 0);
                else begin
                    e9 = q9.pop_front();
                    chk("do9", int'(b9.DO), e9.val);
                    chk("lat9", cnt9, e9.lat);
                    chk("busy9_done", int'(b9.BUSY), 0);
                end
            end
            if (b25.DSO && !dp25) begin
                if (q25.size() == 0) chk("dso25_unexpected", 1, 0);
                else begin
                    e25 = q25.pop_front();
                    chk("do25", int'(b25.DO), e25.val);
                    chk("lat25", cnt25, e25.lat);
                end
            end
        end
        dp9  = b9.DSO;
        dp25 = b25.DSO;
    end

    task automatic send9(input int px[$], input int rank, input bit expect_res);
        if (expect_res && px.size() >= 9)
            q9.push_back('{model(px, 9, rank), (clampr(9, rank) + 1) * 9 + 1});
        foreach (px[i]) begin
            @(posedge CLK); #1;
            b9.DSI = 1'b1;
            b9.DI  = 8'(px[i]);
        end
        @(posedge CLK); #1;
        b9.DSI  = 1'b0;
        b9.RANK = 4'(rank);
    endtask

    task automatic send25(input int px[$], input int rank);
        q25.push_back('{model(px, 25, rank), (clampr(25, rank) + 1) * 25 + 1});
        foreach (px[i]) begin
            @(posedge CLK); #1;
            b25.DSI = 1'b1;
            b25.DI  = 10'(px[i]);
        end
        @(posedge CLK); #1;
        b25.DSI  = 1'b0;
        b25.RANK = 5'(rank);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && (q9.size() != 0 || q25.size() != 0); k++) @(negedge CLK);
        if (q9.size() != 0)  begin chk("timeout9",  q9.size(),  0); q9.delete();  end
        if (q25.size() != 0) begin chk("timeout25", q25.size(), 0); q25.delete(); end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int px[$];
        int e0;
        int n;
        int mode;
        b9.DI = '0;  b9.DSI = 1'b0;  b9.RANK = '0;
        b25.DI = '0; b25.DSI = 1'b0; b25.RANK = '0;
        nRST = 1'b1;
        #2 nRST = 1'b0;
        #1;
        chk("rst_do9",   int'(b9.DO),   0);
        chk("rst_dso9",  int'(b9.DSO),  0);
        chk("rst_busy9", int'(b9.BUSY), 0);
        chk("rst_err9",  int'(b9.ERR),  0);
        chk("rst_do25",  int'(b25.DO),  0);
        chk("rst_dso25", int'(b25.DSO), 0);
        #20 nRST = 1'b1;

        // Median, max, min and clamped rank on the same window
        px = '{9, 3, 7, 1, 5, 8, 2, 6, 4};
        send9(px, 4, 1);  drain();
        send9(px, 0, 1);  drain();
        send9(px, 8, 1);  drain();
        send9(px, 15, 1); drain();

        // Short window: one ERR pulse, previous result kept
        e0 = errs9;
        px = '{10, 20, 30, 40, 50, 60};
        send9(px, 4, 0);
        repeat (3) @(negedge CLK);
        chk("err9_pulses",   errs9 - e0,      1);
        chk("err9_dso",      int'(b9.DSO),    0);
        chk("err9_busy",     int'(b9.BUSY),   0);
        chk("err9_do_kept",  int'(b9.DO),     1);
        chk("err9_err_low",  int'(b9.ERR),    0);

        // Duplicates and flat windows
        px = '{7, 7, 7, 2, 2, 9, 9, 9, 9};
        send9(px, 4, 1); drain();
        px = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        send9(px, 4, 1); drain();
        px = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        send9(px, 4, 1); drain();

        // Over-long window keeps the last nine pixels
        px = '{100, 101, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        send9(px, 4, 1); drain();

        // Abort mid-run: only the second window produces a result
        px = '{50, 60, 70, 80, 90, 40, 30, 20, 10};
        send9(px, 4, 0);
        repeat (20) @(posedge CLK);
        px = '{12, 200, 33, 47, 5, 160, 99, 71, 8};
        send9(px, 4, 1); drain();

        // Asynchronous reset mid-run
        px = '{11, 22, 33, 44, 55, 66, 77, 88, 99};
        send9(px, 8, 0);
        repeat (30) @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("arst_do9",   int'(b9.DO),   0);
        chk("arst_dso9",  int'(b9.DSO),  0);
        chk("arst_busy9", int'(b9.BUSY), 0);
        #3 nRST = 1'b1;
        repeat (80) @(negedge CLK);
        chk("arst_no_result", int'(b9.DSO), 0);

        // Random 3x3 windows
        for (int w = 0; w < 10; w++) begin
            px.delete();
            n = 9 + $urandom_range(0, 2);
            for (int i = 0; i < n; i++) px.push_back($urandom_range(0, 255));
            send9(px, $urandom_range(0, 15), 1);
            drain();
        end

        // Random 5x5 windows over all ranks, with duplicate-heavy and extreme modes
        for (int w = 0; w < 20; w++) begin
            int rk;
            px.delete();
            n = 25 + $urandom_range(0, 2);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                if (mode == 0)      px.push_back($urandom_range(0, 1023));
                else if (mode == 1) px.push_back($urandom_range(0, 3));
                else                px.push_back(($urandom_range(0, 1) != 0) ? 1023 : 0);
            end
            rk = (w == 0) ? 0 : (w == 1) ? 24 : (w == 2) ? 12 : $urandom_range(0, 31);
            send25(px, rk);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
